// File: rtl/ccip_host_mem_responder.sv
// Host-side CCI-P responder: c0 line reads / c1 line writes against a small internal line memory.
// Optional macro CCIP_HOST_MEM_RSP_JITTER_EN adds LFSR-driven pop stalls to vary response latency.

// Generic request FIFO with occupancy count.
// Latency: pushed entry is poppable the cycle after the push edge.
// Backpressure: none; push into a full FIFO is ignored unless a pop frees the slot in the same cycle.
module ccip_hmr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push_vld,
    input  logic [WIDTH-1:0]        i_push_dat,
    input  logic                    i_pop_rdy,
    output logic [WIDTH-1:0]        o_pop_dat,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_CNT);
    assign o_count   = r_count;
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign w_pop     = i_pop_rdy && !o_empty;
    assign w_push    = i_push_vld && (!o_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end
endmodule

// CCI-P host memory responder top.
// Latency: read response RD_LATENCY cycles after c0 pop; write response 1 cycle after c1 pop.
// Backpressure: AFU must honour c0TxAlmFull/c1TxAlmFull; overflowing requests are dropped and flagged.
module ccip_host_mem_responder #(
    parameter int ADDR_WIDTH     = 42,
    parameter int MEM_LINES_LOG2 = 10,
    parameter int MDATA_WIDTH    = 16,
    parameter int REQ_FIFO_DEPTH = 16,
    parameter int ALM_FULL_SLACK = 8,
    parameter int RD_LATENCY     = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   c0_req_valid,
    input  logic [ADDR_WIDTH-1:0]  c0_req_addr,
    input  logic [MDATA_WIDTH-1:0] c0_req_mdata,
    input  logic                   c1_req_valid,
    input  logic [ADDR_WIDTH-1:0]  c1_req_addr,
    input  logic [511:0]           c1_req_data,
    input  logic [MDATA_WIDTH-1:0] c1_req_mdata,
    output logic                   c0TxAlmFull,
    output logic                   c1TxAlmFull,
    output logic                   c0_rsp_valid,
    output logic [511:0]           c0_rsp_data,
    output logic [MDATA_WIDTH-1:0] c0_rsp_mdata,
    output logic                   c1_rsp_valid,
    output logic [MDATA_WIDTH-1:0] c1_rsp_mdata,
    output logic [1:0]             ovf_err
);
    localparam int CW  = $clog2(REQ_FIFO_DEPTH) + 1;
    localparam int C0W = MEM_LINES_LOG2 + MDATA_WIDTH;
    localparam int C1W = MEM_LINES_LOG2 + 512 + MDATA_WIDTH;
    localparam logic [CW-1:0] ALM_THRESH = CW'(REQ_FIFO_DEPTH - ALM_FULL_SLACK);

    logic [511:0]              r_mem [2**MEM_LINES_LOG2];
    logic [RD_LATENCY-1:0]     r_pipe_vld;
    logic [511:0]              r_pipe_dat [RD_LATENCY];
    logic [MDATA_WIDTH-1:0]    r_pipe_md  [RD_LATENCY];
    logic                      r_c1_rsp_vld;
    logic [MDATA_WIDTH-1:0]    r_c1_rsp_md;
    logic                      r_c0_almfull;
    logic                      r_c1_almfull;
    logic [1:0]                r_ovf;

    logic                      w_c0_pop_en;
    logic                      w_c1_pop_en;
    logic                      w_c0_pop;
    logic                      w_c1_pop;
    logic [C0W-1:0]            w_c0_pop_dat;
    logic [C1W-1:0]            w_c1_pop_dat;
    logic [CW-1:0]             w_c0_count;
    logic [CW-1:0]             w_c1_count;
    logic                      w_c0_full;
    logic                      w_c1_full;
    logic                      w_c0_empty;
    logic                      w_c1_empty;
    logic [MEM_LINES_LOG2-1:0] w_c0_idx;
    logic [MEM_LINES_LOG2-1:0] w_c1_idx;
    logic [MDATA_WIDTH-1:0]    w_c0_md;
    logic [MDATA_WIDTH-1:0]    w_c1_md;
    logic [511:0]              w_c1_data;
    logic                      w_c0_drop;
    logic                      w_c1_drop;
    logic                      w_unused_addr;

    // Only the line index is stored; upper address bits alias by design.
    assign w_unused_addr = &{1'b0, c0_req_addr[ADDR_WIDTH-1:MEM_LINES_LOG2],
                             c1_req_addr[ADDR_WIDTH-1:MEM_LINES_LOG2]};

`ifdef CCIP_HOST_MEM_RSP_JITTER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_lfsr <= 16'hACE1;
        else          r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign w_c0_pop_en = (r_lfsr[1:0] != 2'b00);
    assign w_c1_pop_en = (r_lfsr[3:2] != 2'b00);
`else
    assign w_c0_pop_en = 1'b1;
    assign w_c1_pop_en = 1'b1;
`endif

    assign w_c0_pop  = w_c0_pop_en && !w_c0_empty;
    assign w_c1_pop  = w_c1_pop_en && !w_c1_empty;
    assign w_c0_drop = c0_req_valid && w_c0_full && !w_c0_pop;
    assign w_c1_drop = c1_req_valid && w_c1_full && !w_c1_pop;
    assign {w_c0_md, w_c0_idx}            = w_c0_pop_dat;
    assign {w_c1_md, w_c1_data, w_c1_idx} = w_c1_pop_dat;

    ccip_hmr_fifo #(.WIDTH(C0W), .DEPTH(REQ_FIFO_DEPTH)) u_c0_fifo (
        .i_clk      (clk),
        .i_rst_n    (reset_n),
        .i_push_vld (c0_req_valid),
        .i_push_dat ({c0_req_mdata, c0_req_addr[MEM_LINES_LOG2-1:0]}),
        .i_pop_rdy  (w_c0_pop),
        .o_pop_dat  (w_c0_pop_dat),
        .o_count    (w_c0_count),
        .o_full     (w_c0_full),
        .o_empty    (w_c0_empty)
    );

    ccip_hmr_fifo #(.WIDTH(C1W), .DEPTH(REQ_FIFO_DEPTH)) u_c1_fifo (
        .i_clk      (clk),
        .i_rst_n    (reset_n),
        .i_push_vld (c1_req_valid),
        .i_push_dat ({c1_req_mdata, c1_req_data, c1_req_addr[MEM_LINES_LOG2-1:0]}),
        .i_pop_rdy  (w_c1_pop),
        .o_pop_dat  (w_c1_pop_dat),
        .o_count    (w_c1_count),
        .o_full     (w_c1_full),
        .o_empty    (w_c1_empty)
    );

    always_ff @(posedge clk) begin
        if (w_c1_pop) r_mem[w_c1_idx] <= w_c1_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_vld   <= '0;
            r_c1_rsp_vld <= 1'b0;
            r_c1_rsp_md  <= '0;
            r_c0_almfull <= 1'b0;
            r_c1_almfull <= 1'b0;
            r_ovf        <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pipe_dat[i] <= '0;
                r_pipe_md[i]  <= '0;
            end
        end else begin
            r_c0_almfull  <= (w_c0_count >= ALM_THRESH);
            r_c1_almfull  <= (w_c1_count >= ALM_THRESH);
            r_ovf         <= r_ovf | {w_c1_drop, w_c0_drop};
            r_c1_rsp_vld  <= w_c1_pop;
            if (w_c1_pop) r_c1_rsp_md <= w_c1_md;
            r_pipe_vld[0] <= w_c0_pop;
            // Write-first: a same-cycle write to the read index is forwarded.
            if (w_c0_pop) begin
                r_pipe_dat[0] <= (w_c1_pop && (w_c1_idx == w_c0_idx)) ? w_c1_data : r_mem[w_c0_idx];
                r_pipe_md[0]  <= w_c0_md;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_dat[i] <= r_pipe_dat[i-1];
                r_pipe_md[i]  <= r_pipe_md[i-1];
            end
        end
    end

    assign c0TxAlmFull  = r_c0_almfull;
    assign c1TxAlmFull  = r_c1_almfull;
    assign c0_rsp_valid = r_pipe_vld[RD_LATENCY-1];
    assign c0_rsp_data  = r_pipe_dat[RD_LATENCY-1];
    assign c0_rsp_mdata = r_pipe_md[RD_LATENCY-1];
    assign c1_rsp_valid = r_c1_rsp_vld;
    assign c1_rsp_mdata = r_c1_rsp_md;
    assign ovf_err      = r_ovf;
endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Directed self-checking bench for ccip_host_mem_responder (default build, fixed latency).
module tb_ccip_host_mem_responder;
    logic         clk;
    logic         reset_n;
    logic         c0_req_valid;
    logic [41:0]  c0_req_addr;
    logic [15:0]  c0_req_mdata;
    logic         c1_req_valid;
    logic [41:0]  c1_req_addr;
    logic [511:0] c1_req_data;
    logic [15:0]  c1_req_mdata;
    logic         c0TxAlmFull;
    logic         c1TxAlmFull;
    logic         c0_rsp_valid;
    logic [511:0] c0_rsp_data;
    logic [15:0]  c0_rsp_mdata;
    logic         c1_rsp_valid;
    logic [15:0]  c1_rsp_mdata;
    logic [1:0]   ovf_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [511:0] q0_dat[$];
    logic [15:0]  q0_md[$];
    int           q0_cyc[$];
    logic [15:0]  q1_md[$];
    int           q1_cyc[$];
    logic [511:0] model [0:1023];

    ccip_host_mem_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .c0_req_valid (c0_req_valid),
        .c0_req_addr  (c0_req_addr),
        .c0_req_mdata (c0_req_mdata),
        .c1_req_valid (c1_req_valid),
        .c1_req_addr  (c1_req_addr),
        .c1_req_data  (c1_req_data),
        .c1_req_mdata (c1_req_mdata),
        .c0TxAlmFull  (c0TxAlmFull),
        .c1TxAlmFull  (c1TxAlmFull),
        .c0_rsp_valid (c0_rsp_valid),
        .c0_rsp_data  (c0_rsp_data),
        .c0_rsp_mdata (c0_rsp_mdata),
        .c1_rsp_valid (c1_rsp_valid),
        .c1_rsp_mdata (c1_rsp_mdata),
        .ovf_err      (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (c0_rsp_valid) begin
            q0_dat.push_back(c0_rsp_data);
            q0_md.push_back(c0_rsp_mdata);
            q0_cyc.push_back(cyc);
        end
        if (c1_rsp_valid) begin
            q1_md.push_back(c1_rsp_mdata);
            q1_cyc.push_back(cyc);
        end
    end

    task automatic drive(input logic v0, input logic [41:0] a0, input logic [15:0] m0,
                         input logic v1, input logic [41:0] a1, input logic [511:0] d1,
                         input logic [15:0] m1);
        @(negedge clk);
        c0_req_valid = v0; c0_req_addr = a0; c0_req_mdata = m0;
        c1_req_valid = v1; c1_req_addr = a1; c1_req_data = d1; c1_req_mdata = m1;
        if (v1) model[a1[9:0]] = d1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic clr_q();
        q0_dat.delete(); q0_md.delete(); q0_cyc.delete(); q1_md.delete(); q1_cyc.delete();
    endtask

    task automatic wait_rsp(input int n0, input int n1);
        for (int k = 0; k < 100 && (q0_md.size() < n0 || q1_md.size() < n1); k++) @(negedge clk);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        c0_req_valid = 0; c0_req_addr = '0; c0_req_mdata = '0;
        c1_req_valid = 0; c1_req_addr = '0; c1_req_data = '0; c1_req_mdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (c0TxAlmFull !== 1'b0) begin errors++; $display("FAIL rst_c0almfull got %b exp 0", c0TxAlmFull); end
        checks++; if (c1TxAlmFull !== 1'b0) begin errors++; $display("FAIL rst_c1almfull got %b exp 0", c1TxAlmFull); end
        checks++; if (c0_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_c0vld got %b exp 0", c0_rsp_valid); end
        checks++; if (c0_rsp_data !== '0) begin errors++; $display("FAIL rst_c0data got %h exp 0", c0_rsp_data); end
        checks++; if (c1_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_c1vld got %b exp 0", c1_rsp_valid); end
        checks++; if (ovf_err !== 2'b00) begin errors++; $display("FAIL rst_ovf got %b exp 00", ovf_err); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        clr_q();
    endtask

    task automatic test_write_read();
        int wc[8];
        int rc[8];
        clr_q();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, '0, 1'b1, 42'(i), {16{32'(i)}}, 16'(16'h100 + i));
            wc[i] = cyc;
        end
        idle();
        wait_rsp(0, 8);
        checks++; if (q1_md.size() !== 8) begin errors++; $display("FAIL wr_count got %0d exp 8", q1_md.size()); end
        for (int i = 0; i < 8 && i < q1_md.size(); i++) begin
            checks++; if (q1_md[i] !== 16'(16'h100 + i)) begin errors++; $display("FAIL wr_mdata[%0d] got %h exp %h", i, q1_md[i], 16'h100 + i); end
            checks++; if (q1_cyc[i] - wc[i] !== 2) begin errors++; $display("FAIL wr_lat[%0d] got %0d exp 2", i, q1_cyc[i] - wc[i]); end
        end
        clr_q();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 42'(i), 16'(16'h200 + i), 1'b0, '0, '0, '0);
            rc[i] = cyc;
        end
        idle();
        wait_rsp(8, 0);
        checks++; if (q0_md.size() !== 8) begin errors++; $display("FAIL rd_count got %0d exp 8", q0_md.size()); end
        for (int i = 0; i < 8 && i < q0_md.size(); i++) begin
            checks++; if (q0_dat[i] !== {16{32'(i)}}) begin errors++; $display("FAIL rd_data[%0d] got %h exp %h", i, q0_dat[i][31:0], i); end
            checks++; if (q0_md[i] !== 16'(16'h200 + i)) begin errors++; $display("FAIL rd_mdata[%0d] got %h exp %h", i, q0_md[i], 16'h200 + i); end
            checks++; if (q0_cyc[i] - rc[i] !== 5) begin errors++; $display("FAIL rd_lat[%0d] got %0d exp 5", i, q0_cyc[i] - rc[i]); end
        end
    endtask

    task automatic test_same_cycle();
        logic [511:0] b;
        b = {16{32'hB0B0_0005}};
        clr_q();
        drive(1'b1, 42'h5, 16'h0055, 1'b1, 42'h5, b, 16'h0066);
        idle();
        wait_rsp(1, 1);
        checks++; if (q0_dat.size() !== 1) begin errors++; $display("FAIL wf_count got %0d exp 1", q0_dat.size()); end
        if (q0_dat.size() > 0) begin
            checks++; if (q0_dat[0] !== b) begin errors++; $display("FAIL wf_data got %h exp %h", q0_dat[0][31:0], b[31:0]); end
        end
        checks++; if (q1_md.size() !== 1) begin errors++; $display("FAIL wf_c1count got %0d exp 1", q1_md.size()); end
    endtask

    task automatic test_alias();
        logic [511:0] c;
        c = {16{32'hC0C0_0000}};
        clr_q();
        drive(1'b0, '0, '0, 1'b1, 42'h000, c, 16'h0077);
        idle();
        repeat (3) @(negedge clk);
        drive(1'b1, 42'h400, 16'h0088, 1'b0, '0, '0, '0);
        drive(1'b1, 42'h3_0000_0400, 16'h0089, 1'b0, '0, '0, '0);
        idle();
        wait_rsp(2, 1);
        checks++; if (q0_dat.size() !== 2) begin errors++; $display("FAIL alias_count got %0d exp 2", q0_dat.size()); end
        for (int i = 0; i < 2 && i < q0_dat.size(); i++) begin
            checks++; if (q0_dat[i] !== c) begin errors++; $display("FAIL alias_data[%0d] got %h exp %h", i, q0_dat[i][31:0], c[31:0]); end
        end
    endtask

    task automatic test_almfull();
        clr_q();
        force dut.w_c0_pop_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 42'(i % 8), 16'(16'h400 + i), 1'b0, '0, '0, '0);
            checks++; if (c0TxAlmFull !== (i >= 9)) begin errors++; $display("FAIL almfull_rise[%0d] got %b exp %b", i, c0TxAlmFull, i >= 9); end
        end
        idle();
        checks++; if (c1TxAlmFull !== 1'b0) begin errors++; $display("FAIL almfull_c1 got %b exp 0", c1TxAlmFull); end
        release dut.w_c0_pop_en;
        wait_rsp(12, 0);
        checks++; if (q0_md.size() !== 12) begin errors++; $display("FAIL almfull_count got %0d exp 12", q0_md.size()); end
        for (int i = 0; i < 12 && i < q0_md.size(); i++) begin
            checks++; if (q0_md[i] !== 16'(16'h400 + i) || q0_dat[i] !== model[i % 8]) begin
                errors++; $display("FAIL almfull_rsp[%0d] got md %h exp %h", i, q0_md[i], 16'h400 + i); end
        end
        checks++; if (ovf_err !== 2'b00) begin errors++; $display("FAIL almfull_ovf got %b exp 00", ovf_err); end
        checks++; if (c0TxAlmFull !== 1'b0) begin errors++; $display("FAIL almfull_fall got %b exp 0", c0TxAlmFull); end
    endtask

    task automatic test_overflow();
        clr_q();
        force dut.w_c0_pop_en = 1'b0;
        for (int i = 0; i < 16; i++) drive(1'b1, 42'(i % 8), 16'(16'h500 + i), 1'b0, '0, '0, '0);
        drive(1'b1, 42'h1, 16'h05FF, 1'b0, '0, '0, '0);
        checks++; if (ovf_err !== 2'b00) begin errors++; $display("FAIL ovf_before got %b exp 00", ovf_err); end
        idle();
        checks++; if (ovf_err !== 2'b01) begin errors++; $display("FAIL ovf_set got %b exp 01", ovf_err); end
        repeat (3) @(negedge clk);
        release dut.w_c0_pop_en;
        wait_rsp(16, 0);
        checks++; if (q0_md.size() !== 16) begin errors++; $display("FAIL ovf_count got %0d exp 16", q0_md.size()); end
        for (int i = 0; i < 16 && i < q0_md.size(); i++) begin
            checks++; if (q0_md[i] !== 16'(16'h500 + i)) begin errors++; $display("FAIL ovf_md[%0d] got %h exp %h", i, q0_md[i], 16'h500 + i); end
        end
        checks++; if (ovf_err !== 2'b01) begin errors++; $display("FAIL ovf_sticky got %b exp 01", ovf_err); end
    endtask

    task automatic test_reset_inflight();
        int rc;
        clr_q();
        force dut.w_c0_pop_en = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b1, 42'(i % 8), 16'(16'h600 + i), 1'b0, '0, '0, '0);
        idle();
        checks++; if (c0TxAlmFull !== 1'b1) begin errors++; $display("FAIL rsti_almfull_pre got %b exp 1", c0TxAlmFull); end
        release dut.w_c0_pop_en;
        for (int k = 0; k < 30 && !c0_rsp_valid; k++) @(negedge clk);
        checks++; if (c0_rsp_valid !== 1'b1) begin errors++; $display("FAIL rsti_vld_pre got %b exp 1", c0_rsp_valid); end
        checks++; if (ovf_err !== 2'b01) begin errors++; $display("FAIL rsti_ovf_pre got %b exp 01", ovf_err); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (c0_rsp_valid !== 1'b0) begin errors++; $display("FAIL rsti_c0vld got %b exp 0", c0_rsp_valid); end
        checks++; if (c0_rsp_data !== '0 || c0_rsp_mdata !== '0) begin errors++; $display("FAIL rsti_c0dat got md %h exp 0", c0_rsp_mdata); end
        checks++; if (c0TxAlmFull !== 1'b0) begin errors++; $display("FAIL rsti_almfull got %b exp 0", c0TxAlmFull); end
        checks++; if (ovf_err !== 2'b00) begin errors++; $display("FAIL rsti_ovf got %b exp 00", ovf_err); end
        repeat (2) @(negedge clk);
        clr_q();
        drive(1'b1, 42'h1, 16'h07AB, 1'b0, '0, '0, '0);
        reset_n = 1'b1;
        rc = cyc;
        idle();
        repeat (20) @(negedge clk);
        checks++; if (q0_md.size() !== 1) begin errors++; $display("FAIL rsti_count got %0d exp 1", q0_md.size()); end
        if (q0_md.size() > 0) begin
            checks++; if (q0_md[0] !== 16'h07AB) begin errors++; $display("FAIL rsti_md got %h exp 07ab", q0_md[0]); end
            checks++; if (q0_cyc[0] - rc !== 5) begin errors++; $display("FAIL rsti_lat got %0d exp 5", q0_cyc[0] - rc); end
        end
    endtask

    task automatic test_full_push_pop();
        clr_q();
        force dut.w_c0_pop_en = 1'b0;
        for (int i = 0; i < 16; i++) drive(1'b1, 42'(i % 8), 16'(16'h800 + i), 1'b0, '0, '0, '0);
        drive(1'b1, 42'h2, 16'h0810, 1'b0, '0, '0, '0);
        release dut.w_c0_pop_en;
        idle();
        checks++; if (ovf_err !== 2'b00) begin errors++; $display("FAIL fpp_ovf got %b exp 00", ovf_err); end
        wait_rsp(17, 0);
        checks++; if (q0_md.size() !== 17) begin errors++; $display("FAIL fpp_count got %0d exp 17", q0_md.size()); end
        for (int i = 0; i < 17 && i < q0_md.size(); i++) begin
            checks++; if (q0_md[i] !== 16'(16'h800 + i)) begin errors++; $display("FAIL fpp_md[%0d] got %h exp %h", i, q0_md[i], 16'h800 + i); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_cycle();
        test_alias();
        test_almfull();
        test_overflow();
        test_reset_inflight();
        test_full_push_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
